// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and byte-lane helper for the data
//               memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BEAT_W         = 2;

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BYTES_PER_WORD - 1);

    // Big-endian lane select: beat 0 is the most significant byte.
    function automatic logic [7:0] be_byte_sel(input logic [31:0]       word,
                                               input logic [BEAT_W-1:0] beat);
        logic [7:0] v;
        v = word[31:24];
        case (beat)
            2'd0:    v = word[31:24];
            2'd1:    v = word[23:16];
            2'd2:    v = word[15:8];
            default: v = word[7:0];
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_ram.sv
// ============================================================================
// Module      : byte_ram
// Description : Single-port byte array, synchronous write, asynchronous read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_ram #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    output logic [7:0]        o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    // Contents are deliberately left unreset.
    logic [7:0] r_mem [0:c_DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Word load/store responder doing four big-endian byte beats
//               on a byte array, completing with a one-cycle ack pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        be,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              misaligned,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_mis;

    logic                w_accept;
    logic                w_in_xfer;
    logic [ADDR_W-1:0]   w_byte_addr;
    logic                w_ram_we;
    logic [7:0]          w_ram_wdata;
    logic [7:0]          w_ram_rdata;

    assign w_accept    = (r_state == IDLE) && req;
    assign w_in_xfer   = (r_state == XFER);
    assign w_byte_addr = r_addr + ADDR_W'(r_beat);
    assign w_ram_wdata = be_byte_sel(r_wdata, r_beat);
    assign w_ram_we    = w_in_xfer && r_we && r_be[c_LAST_BEAT - r_beat];

    byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_byte_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        ack         = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (r_beat == c_LAST_BEAT) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                ack         = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= addr;
                r_we    <= we;
                r_wdata <= wdata;
                r_be    <= be;
                r_beat  <= '0;
                r_mis   <= (addr[1:0] != 2'b00);
            end else if (w_in_xfer) begin
                r_beat <= r_beat + 1'b1;
                // Loads shift MSB-first so the word is assembled after beat 3.
                if (!r_we) begin
                    r_rdata <= {r_rdata[DATA_W-9:0], w_ram_rdata};
                end
            end
        end
    end

    assign rdata      = r_rdata;
    assign misaligned = r_mis;

endmodule

`default_nettype wire
